// File: rtl/vfo_divider.sv
// Digitally controlled oscillator: PLLClock half-period is DivValue ClockIn cycles, nudged by AdjustFreq.
// Optional lock detector built only when VFO_LOCK_DETECT_EN is defined; otherwise Locked is tied low.
`timescale 1ns/1ps
module vfo_divider #(
  parameter int DIV_WIDTH  = 5,
  parameter int DIV_INIT   = 16,
  parameter int DIV_MIN    = 2,
  parameter int DIV_MAX    = 31,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 ClockIn,
  input  logic                 Reset,
  input  logic [1:0]           AdjustFreq,
  output logic                 PLLClock,
  output logic [DIV_WIDTH-1:0] DivValue,
  output logic                 Saturated,
  output logic                 Locked
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = '0;
  localparam logic [DIV_WIDTH-1:0] INIT_V   = DIV_INIT[DIV_WIDTH-1:0];
  localparam logic [DIV_WIDTH-1:0] MIN_V    = DIV_MIN[DIV_WIDTH-1:0];
  localparam logic [DIV_WIDTH-1:0] MAX_V    = DIV_MAX[DIV_WIDTH-1:0];

  logic [DIV_WIDTH-1:0] halfCnt;
  logic [DIV_WIDTH-1:0] divNext;
  logic                 halfEnd;
  logic                 riseToggle;
  logic                 speedUp;
  logic                 slowDown;

  assign speedUp    = (AdjustFreq == 2'b11);
  assign slowDown   = (AdjustFreq == 2'b00);
  assign halfEnd    = (halfCnt == DivValue - DIV_ONE);
  // AdjustFreq only matters on the edge where PLLClock is about to go high.
  assign riseToggle = halfEnd && !PLLClock;
  assign Saturated  = (DivValue == MIN_V) || (DivValue == MAX_V);

  always_comb begin
    divNext = DivValue;
    if (riseToggle) begin
      if (speedUp && (DivValue > MIN_V)) begin
        divNext = DivValue - DIV_ONE;
      end else if (slowDown && (DivValue < MAX_V)) begin
        divNext = DivValue + DIV_ONE;
      end
    end
  end

  // The divisor update lands together with the counter clear, so the new
  // half-period (the high phase) already runs on the updated value.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      halfCnt  <= DIV_ZERO;
      PLLClock <= 1'b0;
      DivValue <= INIT_V;
    end else begin
      if (halfEnd) begin
        halfCnt  <= DIV_ZERO;
        PLLClock <= ~PLLClock;
      end else begin
        halfCnt <= halfCnt + DIV_ONE;
      end
      DivValue <= divNext;
    end
  end

`ifdef VFO_LOCK_DETECT_EN
  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} lockState_t;

  localparam logic [3:0] LOCK_V = LOCK_COUNT[3:0];

  lockState_t lockState;
  logic [3:0] lockCnt;
  logic       steady;

  assign steady = (AdjustFreq == 2'b01);

  // Code 10 counts as "no change" for the divisor but neither advances nor
  // clears the acquisition run.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      lockState <= ACQUIRE;
      lockCnt   <= 4'd0;
      Locked    <= 1'b0;
    end else if (riseToggle) begin
      case (lockState)
        ACQUIRE: begin
          if (speedUp || slowDown) begin
            lockCnt <= 4'd0;
          end else if (steady) begin
            if (lockCnt + 4'd1 == LOCK_V) begin
              lockState <= LOCKED;
              lockCnt   <= 4'd0;
              Locked    <= 1'b1;
            end else begin
              lockCnt <= lockCnt + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (speedUp || slowDown) begin
            lockState <= ACQUIRE;
            lockCnt   <= 4'd0;
            Locked    <= 1'b0;
          end
        end
        default: begin
          lockState <= ACQUIRE;
          lockCnt   <= 4'd0;
          Locked    <= 1'b0;
        end
      endcase
    end
  end
`else
  assign Locked = 1'b0;
`endif

endmodule

// File: doc/vfo_divider.md
VFO_DIVIDER -- requirements
Module: vfo_divider

Interface
REQ-001 Parameter DIV_WIDTH, default 5; width of the half-period divisor.
REQ-002 Parameter DIV_INIT, default 16; divisor loaded at reset.
REQ-003 Parameter DIV_MIN, default 2; lowest divisor, at least 1.
REQ-004 Parameter DIV_MAX, default 31; highest divisor, at most 2^DIV_WIDTH-1.
REQ-005 Parameter LOCK_COUNT, default 4; consecutive 01 samples needed for lock, range 1..15.
REQ-006 ClockIn  input  1  single master clock; all state changes on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-008 AdjustFreq  input  [1:0]  upstream comparator code: 11 = speed up, 00 = slow down, 01 = no change, 10 = no change.
REQ-009 PLLClock  output  1  generated oscillator clock, registered, returned to the comparator.
REQ-010 DivValue  output  [DIV_WIDTH-1:0]  current half-period divisor.
REQ-011 Saturated  output  1  high while DivValue equals DIV_MIN or DIV_MAX.
REQ-012 Locked  output  1  lock indicator; see Configuration.

Function
REQ-013 Internal HalfCnt counts ClockIn cycles from 0 to DivValue-1; when HalfCnt==DivValue-1, it clears to 0 and PLLClock toggles.
REQ-014 Half-period = DivValue ClockIn cycles; full PLLClock period = 2*DivValue cycles.
REQ-015 AdjustFreq is sampled only on the cycle PLLClock toggles 0->1 (rising toggle); all other cycles ignore it.
REQ-016 Sampled 11: DivValue <= DivValue-1, unless DivValue==DIV_MIN (hold).
REQ-017 Sampled 00: DivValue <= DivValue+1, unless DivValue==DIV_MAX (hold).
REQ-018 Sampled 01 or 10: DivValue unchanged.
REQ-019 Divisor arithmetic never wraps; saturation at DIV_MIN/DIV_MAX is the only limit behaviour.
REQ-020 A new DivValue takes effect from the half-period that begins on the same rising toggle; the high phase uses the updated value.
REQ-021 Saturated is combinational from DivValue; no extra latency.
REQ-022 Lock FSM states ACQUIRE and LOCKED; LockCnt is 4 bits.
REQ-023 ACQUIRE: a sampled 01 increments LockCnt; a sampled 00 or 11 clears it; a sampled 10 holds it.
REQ-024 ACQUIRE: when LockCnt reaches LOCK_COUNT, go to LOCKED and set Locked=1 on that same edge.
REQ-025 LOCKED: a sampled 00 or 11 goes to ACQUIRE with LockCnt=0 and Locked=0 on that edge; 01 or 10 stays in LOCKED.
REQ-026 A divisor adjustment and the lock transition triggered by the same sample occur on the same edge.

Reset
REQ-027 While Reset==0, all state is forced immediately, independent of ClockIn: PLLClock=0, HalfCnt=0, DivValue=DIV_INIT, LockCnt=0, FSM=ACQUIRE, Locked=0.
REQ-028 A reset asserted mid-period aborts the period; no partial pulse is extended.
REQ-029 After Reset rises, the first PLLClock rising toggle occurs DIV_INIT cycles later.

Configuration
REQ-030 Macro VFO_LOCK_DETECT_EN defined: the lock FSM, LockCnt and the Locked output behave per REQ-022..REQ-026.
REQ-031 Macro VFO_LOCK_DETECT_EN not defined: no lock FSM or LockCnt is built, and Locked is tied to 0; all other behaviour is identical.

Verification
REQ-032 Reset, then AdjustFreq=01 held -> DivValue=16, PLLClock rises 16 cycles after Reset release, period 32, Saturated=0.
REQ-033 AdjustFreq=11 held for 20 rising toggles from DivValue=16 -> DivValue steps 15,14,...,2 and holds at 2, Saturated=1, period 4.
REQ-034 AdjustFreq=00 held from DivValue=16 -> DivValue reaches 31 after 15 samples, holds at 31, Saturated=1, period 62.
REQ-035 VFO_LOCK_DETECT_EN defined, AdjustFreq=01 -> Locked=1 on the 4th rising toggle; then a single 11 sample -> Locked=0 and DivValue=15 on the same edge; a 10 sample in ACQUIRE leaves LockCnt unchanged.
REQ-036 Reset driven 0 for 3 cycles in the middle of a high phase with DivValue=20 -> PLLClock=0 and DivValue=16 immediately, without waiting for a ClockIn edge; normal timing resumes per REQ-029.
REQ-037 Build without VFO_LOCK_DETECT_EN and rerun REQ-035 stimulus -> Locked stays 0 throughout, and DivValue and PLLClock match the macro-defined build cycle for cycle.
